// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } pipe_state_e;

    // X31 reads as zero, so it never carries a data dependency.
    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         resetl,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, branch flush, memory freeze and watchdog for the 5-stage pipeline.
// Control outputs are combinational so they gate pipeline registers on the same edge.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic [4:0]       id_rf1,
    input  logic [4:0]       id_rf2,
    input  logic             id_rf1_used,
    input  logic             id_rf2_used,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_pc_src,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic             mem_timeout
);

    localparam int unsigned        WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    pipe_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              loaduse;
    logic              freeze;

    assign loaduse = ex_memread && (ex_rd != XZR) &&
                     ((id_rf1_used && (id_rf1 == ex_rd)) ||
                      (id_rf2_used && (id_rf2 == ex_rd)));
    assign freeze  = mem_access && !dmem_ready;

    always_ff @(posedge clk) begin
        if (!resetl) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // The chosen action for this cycle doubles as the next registered state.
    always_comb begin
        state_d = ST_RUN;
        if (!resetl) begin
            state_d = ST_RUN;
        end else if (freeze) begin
            state_d = ST_FREEZE;
        end else if (mem_pc_src) begin
            state_d = ST_FLUSH;
        end else if (loaduse) begin
            state_d = ST_STALL;
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (!resetl) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            unique case (state_d)
                ST_RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
                ST_STALL: begin
                    idex_bubble = 1'b1;
                end
                ST_FLUSH: begin
                    pc_write     = 1'b1;
                    ifid_write   = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    exmem_bubble = 1'b1;
                end
                ST_FREEZE: begin
                    pipe_freeze = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Watchdog saturates at the threshold so the sticky flag keeps its cause.
    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (state_d == ST_FREEZE) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetl (resetl),
        .inc    (state_d == ST_STALL),
        .count  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .resetl (resetl),
        .inc    (state_d == ST_FLUSH),
        .count  (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk    (clk),
        .resetl (resetl),
        .inc    (state_d == ST_FREEZE),
        .count  (freeze_cnt)
    );

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

endmodule
